// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction memory and IF/ID bus
//
// Groups every non-clock/reset signal of fetch_stage.
//   master : the fetch stage (drives imem_addr, IF/ID fields, status)
//   slave  : the surrounding core (drives stall/redirect/halt, returns imem_instr)
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_target, halt_req, imem_instr,
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid,
           halted, fetch_fault, fault_pc, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_target, halt_req, imem_instr,
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid,
           halted, fetch_fault, fault_pc, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage with PC, IF/ID register and fault detection
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fetch_stage_if.master - stall/redirect/halt inputs, combinational
//           instruction memory (imem_addr -> imem_instr), IF/ID outputs,
//           halted / fetch_fault / fault_pc / fetch_count status
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int          IMEM_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_id_instr, w_id_instr_nxt;
  logic [31:0] r_id_pc, w_id_pc_nxt;
  logic [31:0] r_id_pc_plus4, w_id_pc_plus4_nxt;
  logic        r_id_valid, w_id_valid_nxt;
  logic        r_fault, w_fault_nxt;
  logic [31:0] r_fault_pc, w_fault_pc_nxt;
  logic [31:0] r_count, w_count_nxt;

  logic w_target_bad;
  logic w_pc_oob;

  assign w_target_bad = (bus.redirect_target[1:0] != 2'b00) || (bus.redirect_target >= PC_LIMIT);
  assign w_pc_oob     = (r_pc >= PC_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_id_instr    <= NOP_INSTR;
      r_id_pc       <= 32'h0;
      r_id_pc_plus4 <= 32'h4;
      r_id_valid    <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_pc    <= 32'h0;
      r_count       <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_id_instr    <= w_id_instr_nxt;
      r_id_pc       <= w_id_pc_nxt;
      r_id_pc_plus4 <= w_id_pc_plus4_nxt;
      r_id_valid    <= w_id_valid_nxt;
      r_fault       <= w_fault_nxt;
      r_fault_pc    <= w_fault_pc_nxt;
      r_count       <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_id_instr_nxt    = r_id_instr;
    w_id_pc_nxt       = r_id_pc;
    w_id_pc_plus4_nxt = r_id_pc_plus4;
    w_id_valid_nxt    = r_id_valid;
    w_fault_nxt       = r_fault;
    w_fault_pc_nxt    = r_fault_pc;
    w_count_nxt       = r_count;

    case (r_state)
      BOOT: begin
        w_state_nxt    = RUN;
        w_id_valid_nxt = 1'b0;
      end

      RUN: begin
        if (bus.halt_req) begin
          w_state_nxt    = HALTED;
          w_id_valid_nxt = 1'b0;
          w_id_instr_nxt = NOP_INSTR;
        end else if (bus.redirect) begin
          w_id_valid_nxt = 1'b0;
          w_id_instr_nxt = NOP_INSTR;
          if (w_target_bad) begin
            w_state_nxt    = HALTED;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = bus.redirect_target;
          end else begin
            // Squash the wrong-path word; the target is fetched next edge.
            w_pc_nxt = bus.redirect_target;
          end
        end else if (bus.stall) begin
          // Hold everything.
        end else if (w_pc_oob) begin
          w_state_nxt    = HALTED;
          w_fault_nxt    = 1'b1;
          w_fault_pc_nxt = r_pc;
          w_id_valid_nxt = 1'b0;
          w_id_instr_nxt = NOP_INSTR;
        end else begin
          w_id_instr_nxt    = bus.imem_instr;
          w_id_pc_nxt       = r_pc;
          w_id_pc_plus4_nxt = r_pc + 32'd4;
          w_id_valid_nxt    = 1'b1;
          w_pc_nxt          = r_pc + 32'd4;
          w_count_nxt       = r_count + 32'd1;
        end
      end

      HALTED: begin
        w_id_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign bus.imem_addr   = r_pc;
  assign bus.id_instr    = r_id_instr;
  assign bus.id_pc       = r_id_pc;
  assign bus.id_pc_plus4 = r_id_pc_plus4;
  assign bus.id_valid    = r_id_valid;
  assign bus.halted      = (r_state == HALTED);
  assign bus.fetch_fault = r_fault;
  assign bus.fault_pc    = r_fault_pc;
  assign bus.fetch_count = r_count;

endmodule
